// File: rtl/xoodoo_pkg.sv
// Shared constants, round-constant table and helpers for the Xoodoo permutation core.
package xoodoo_pkg;

    localparam int LANE_W  = 32;
    localparam int NLANE_X = 4;
    localparam int NPLANE  = 3;
    localparam int STATE_W = LANE_W * NLANE_X * NPLANE;
    localparam int NRC     = 12;

    // Element 0 sits in the most significant slot because of the [0:NRC-1] ordering.
    localparam logic [0:NRC-1][LANE_W-1:0] RC = {
        32'h0000_0058, 32'h0000_0038, 32'h0000_03C0, 32'h0000_00D0,
        32'h0000_0120, 32'h0000_0014, 32'h0000_0060, 32'h0000_002C,
        32'h0000_0380, 32'h0000_00F0, 32'h0000_01A0, 32'h0000_0012
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic int lane_lo(input int x, input int y);
        return LANE_W * (x + NLANE_X * y);
    endfunction

    function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v, input int n);
        return (v << n) | (v >> (LANE_W - n));
    endfunction

    function automatic logic [LANE_W-1:0] rc_at(input logic [3:0] idx);
        if (idx >= 4'(NRC)) begin
            return '0;
        end
        return RC[idx];
    endfunction

endpackage

// File: rtl/xoodoo_round.sv
// One combinational Xoodoo round: theta, rho-west, iota, chi, rho-east.
module xoodoo_round
    import xoodoo_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic [LANE_W-1:0]  rc_i,
    output logic [STATE_W-1:0] state_o
);
    genvar gi, gj;

    logic [LANE_W-1:0] a_w  [NPLANE][NLANE_X];
    logic [LANE_W-1:0] th_w [NPLANE][NLANE_X];
    logic [LANE_W-1:0] rw_w [NPLANE][NLANE_X];
    logic [LANE_W-1:0] ch_w [NPLANE][NLANE_X];
    logic [LANE_W-1:0] p_w  [NLANE_X];
    logic [LANE_W-1:0] e_w  [NLANE_X];

    for (gi = 0; gi < NLANE_X; gi++) begin : g_col
        assign p_w[gi] = a_w[0][gi] ^ a_w[1][gi] ^ a_w[2][gi];
        assign e_w[gi] = rotl(p_w[(gi + 3) % 4], 5) ^ rotl(p_w[(gi + 3) % 4], 14);
    end

    for (gj = 0; gj < NPLANE; gj++) begin : g_plane
        for (gi = 0; gi < NLANE_X; gi++) begin : g_lane
            assign a_w[gj][gi]  = state_i[lane_lo(gi, gj) +: LANE_W];
            assign th_w[gj][gi] = a_w[gj][gi] ^ e_w[gi];

            // Iota lands in plane 0 here since rho-west leaves that plane untouched.
            if (gj == 0 && gi == 0) begin : g_iota
                assign rw_w[gj][gi] = th_w[0][0] ^ rc_i;
            end else if (gj == 0) begin : g_p0
                assign rw_w[gj][gi] = th_w[0][gi];
            end else if (gj == 1) begin : g_p1
                assign rw_w[gj][gi] = th_w[1][(gi + 3) % 4];
            end else begin : g_p2
                assign rw_w[gj][gi] = rotl(th_w[2][gi], 11);
            end

            assign ch_w[gj][gi] = rw_w[gj][gi]
                                ^ (~rw_w[(gj + 1) % 3][gi] & rw_w[(gj + 2) % 3][gi]);

            if (gj == 0) begin : g_e0
                assign state_o[lane_lo(gi, gj) +: LANE_W] = ch_w[0][gi];
            end else if (gj == 1) begin : g_e1
                assign state_o[lane_lo(gi, gj) +: LANE_W] = rotl(ch_w[1][gi], 1);
            end else begin : g_e2
                assign state_o[lane_lo(gi, gj) +: LANE_W] = rotl(ch_w[2][(gi + 2) % 4], 8);
            end
        end
    end

endmodule

// File: rtl/xoodoo_perm.sv
// Iterative Xoodoo[NROUNDS] core with start/done handshake.
// Define XOODOO_UNROLL2_EN to run two rounds per clock.
module xoodoo_perm
    import xoodoo_pkg::*;
#(
    parameter int NROUNDS = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [STATE_W-1:0] state_in,
    output logic [STATE_W-1:0] state_out,
    output logic               done,
    output logic               busy
);
    localparam logic [3:0] FIRST_IDX = 4'(NRC - NROUNDS);

    state_e             state_q, state_d;
    logic [STATE_W-1:0] work_q, work_d;
    logic [3:0]         idx_q, idx_d;
    logic [STATE_W-1:0] round_out;
    logic [3:0]         step;
    logic               last_round;

`ifdef XOODOO_UNROLL2_EN
    logic [STATE_W-1:0] mid_state;
    logic [STATE_W-1:0] pair_state;
    logic               single;

    // Odd remaining count only happens on the first cycle of an odd-length run.
    assign single = idx_q[0];

    xoodoo_round u_round0 (
        .state_i (work_q),
        .rc_i    (rc_at(idx_q)),
        .state_o (mid_state)
    );

    xoodoo_round u_round1 (
        .state_i (mid_state),
        .rc_i    (rc_at(idx_q + 4'd1)),
        .state_o (pair_state)
    );

    assign round_out = single ? mid_state : pair_state;
    assign step      = single ? 4'd1 : 4'd2;
`else
    xoodoo_round u_round0 (
        .state_i (work_q),
        .rc_i    (rc_at(idx_q)),
        .state_o (round_out)
    );

    assign step = 4'd1;
`endif

    assign last_round = (idx_q + step) >= 4'(NRC);
    assign state_out  = work_q;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        idx_d   = idx_q;
        done    = 1'b0;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d  = state_in;
                    idx_d   = FIRST_IDX;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                work_d = round_out;
                idx_d  = idx_q + step;
                if (last_round) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    work_d  = state_in;
                    idx_d   = FIRST_IDX;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: doc/xoodoo_perm.md
Name: xoodoo_perm

Overview:
- Iterative Xoodoo[NROUNDS] permutation core. It is the responder side of the xoodyak controller's permutation handshake.
- The controller drives its enable pulse and 384-bit state into this block. The block runs the rounds and returns the permuted state with a one-cycle complete pulse, which the controller latches into its state register.
- Default configuration is one round per clock.

Parameters:
- NROUNDS, 12, number of rounds (1..12). The block applies the last NROUNDS constants of the 12-entry table.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  permutation request; driven by the controller's xoodoo_enable
- state_in  input  384  state to permute; driven by the controller's state_out; sampled when start is accepted
- state_out  output  384  permuted state; feeds the controller's state_in
- done  output  1  one-cycle pulse, state_out valid; feeds the controller's xoodoo_complete
- busy  output  1  high while rounds are in progress

Behaviour:
- State layout: lane (x,y), x=0..3, y=0..2, occupies bits [32*(x+4y)+31 : 32*(x+4y)]. Plane y=0 is bits [127:0]. All rotations are left rotations on 32-bit lanes.
- Round, applied to planes A0, A1, A2, in this order:
  - theta: P[x] = A0[x]^A1[x]^A2[x]; E[x] = rotl(P[x-1 mod 4],5) ^ rotl(P[x-1 mod 4],14); Ay[x] ^= E[x].
  - rho-west: A1[x] = A1[x-1 mod 4]; A2[x] = rotl(A2[x],11).
  - iota: A0[0] ^= RC[i].
  - chi: B0 = ~A1&A2, B1 = ~A2&A0, B2 = ~A0&A1 (all from pre-chi values); Ay ^= By.
  - rho-east: A1[x] = rotl(A1[x],1); A2[x] = rotl(A2[x+2 mod 4],8).
- RC table, index 0..11: 0x058, 0x038, 0x3C0, 0x0D0, 0x120, 0x014, 0x060, 0x02C, 0x380, 0x0F0, 0x1A0, 0x012. The run starts at index 12-NROUNDS and ends at index 11.
- FSM IDLE -> RUN -> DONE:
  - IDLE: on start, load state_in into the working register, set round index to 12-NROUNDS, go to RUN.
  - RUN: each cycle, apply one round to the register and increment the index. After the round with index 11, go to DONE.
  - DONE: done=1 for exactly this cycle. Return to IDLE. If start is high in DONE, accept it and go directly to RUN (back-to-back).
- Latency: start sampled in cycle T gives done high in cycle T+NROUNDS+1 (13 for the default). This is within the controller's 18-cycle permutation window.
- busy=1 in RUN, 0 in IDLE and DONE.
- start while busy: ignored; no restart, no error.
- state_out continuously shows the working register. It is valid and stable from the done cycle until the next accepted start. It must not change while in IDLE.
- Reset: state FSM=IDLE, working register=0, so state_out=0. done=0, busy=0. Reset during RUN aborts the run with no done pulse. Reset has priority over start in the same cycle.

Optional Feature:
- Macro XOODOO_UNROLL2_EN.
- Defined: two chained round instances per cycle, index advances by 2, latency ceil(NROUNDS/2)+1 (7 at default). For odd NROUNDS the first RUN cycle applies a single round so the run ends on index 11.
- Undefined: one round per cycle, as above.
- Results must be bit-identical in both builds.

Decomposition:
- Package xoodoo_pkg:
  - lane/plane width constants (32, 4, 3)
  - 12-entry RC array
  - FSM state typedef
  - lane-index helper function
- Sub-module xoodoo_round: purely combinational; inputs 384-bit state and 32-bit RC, output 384-bit state. Instantiated once, or twice under XOODOO_UNROLL2_EN.

Test Plan:
- NROUNDS=1, state_in=0, start pulse -> done 2 cycles later; state_out[31:0]=0x00000012, state_out[159:128]=0x00000024, all other bits 0.
- NROUNDS=12, state_in=0 -> done exactly 13 cycles after start; state_out equals the team C model's Xoodoo[12](0); busy high for 12 cycles.
- start re-asserted on cycles 3..8 of a run -> ignored; single done at cycle 13; result unchanged versus the clean run.
- start asserted in the done cycle with a new random state -> second done 13 cycles later; both results match the model; state_out stable between done and the following start.
- reset asserted mid-run (cycle 6) -> no done pulse; state_out=0; busy=0; next start completes correctly.
- Controller loopback: xoodyak absorbing a 16-byte message -> xoodoo_complete seen before counter 0x12; latched state matches the model; repeat with XOODOO_UNROLL2_EN defined (done at cycle 7).
